// File: rtl/sobel_window_buffer.sv
// sobel_window_buffer: raster pixel stream to 3x3 neighbourhoods for Sobel.
// Two shift-register line buffers; optional zero-padded borders with flush.
module sobel_window_buffer #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 6,
    parameter int IMG_H    = 5,
    parameter int PAD_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] grayscale_i,
    input  logic              done_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] d0_o,
    output logic [DATA_W-1:0] d1_o,
    output logic [DATA_W-1:0] d2_o,
    output logic [DATA_W-1:0] d3_o,
    output logic [DATA_W-1:0] d4_o,
    output logic [DATA_W-1:0] d5_o,
    output logic [DATA_W-1:0] d6_o,
    output logic [DATA_W-1:0] d7_o,
    output logic [DATA_W-1:0] d8_o,
    output logic              done_o,
    output logic              sof_o,
    output logic              eof_o
);

    localparam int   CW  = $clog2(IMG_W);
    localparam int   RW  = $clog2(IMG_H + 2);
    localparam logic PAD = (PAD_MODE != 0);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_n;
    logic [CW-1:0]     r_col;
    logic [CW-1:0]     w_col_n;
    logic [CW-1:0]     w_c;
    logic [RW-1:0]     r_row;
    logic [RW-1:0]     w_row_n;
    logic [RW-1:0]     w_r;
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_t1, r_t2;
    logic [DATA_W-1:0] r_m1, r_m2;
    logic [DATA_W-1:0] r_b1, r_b2;
    logic [DATA_W-1:0] w_pix;
    logic [DATA_W-1:0] w_lb0o;
    logic [DATA_W-1:0] w_lb1o;
    logic [DATA_W-1:0] w_win [9];
    logic              w_adv;
    logic              w_last_px;
    logic              w_last_fl;
    logic              w_trig;
    logic              w_sof;
    logic              w_eof;
    logic              w_mt, w_mb, w_ml, w_mr;

    assign ready_o = (r_state == S_RUN);

    // Counters keep running through the flush rows (IMG_H, IMG_H+1)
    always_comb begin
        w_state_n = r_state;
        w_col_n   = r_col;
        w_row_n   = r_row;
        w_adv     = 1'b0;
        w_pix     = grayscale_i;
        w_last_px = (r_row == RW'(IMG_H - 1))
                 && (r_col == CW'(IMG_W - 1));
        w_last_fl = (r_row == RW'(IMG_H + 1))
                 && (r_col == '0);
        unique case (r_state)
            S_RUN:   w_adv = done_i;
            S_FLUSH: begin
                w_adv = 1'b1;
                w_pix = '0;
            end
        endcase
        if (w_adv) begin
            if (r_col == CW'(IMG_W - 1)) begin
                w_col_n = '0;
                w_row_n = r_row + RW'(1);
            end else begin
                w_col_n = r_col + CW'(1);
            end
            if (r_state == S_RUN && w_last_px) begin
                if (PAD) w_state_n = S_FLUSH;
                else     w_row_n   = '0;
            end
            if (r_state == S_FLUSH && w_last_fl) begin
                w_state_n = S_RUN;
                w_col_n   = '0;
                w_row_n   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RUN;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_n;
            r_col   <= w_col_n;
            r_row   <= w_row_n;
        end
    end

    // Window centre lags the incoming pixel by one line plus one pixel
    always_comb begin
        w_lb0o = r_lb0[IMG_W-1];
        w_lb1o = r_lb1[IMG_W-1];
        if (r_col == '0) begin
            w_c = CW'(IMG_W - 1);
            w_r = r_row - RW'(2);
        end else begin
            w_c = r_col - CW'(1);
            w_r = r_row - RW'(1);
        end
        if (PAD) begin
            w_trig = w_adv && ((r_row >= RW'(2))
                  || (r_row == RW'(1) && r_col != '0));
            w_sof  = (w_r == '0) && (w_c == '0);
            w_eof  = (w_r == RW'(IMG_H - 1))
                  && (w_c == CW'(IMG_W - 1));
        end else begin
            w_trig = w_adv && (r_row >= RW'(2))
                  && (r_col >= CW'(2));
            w_sof  = (w_r == RW'(1)) && (w_c == CW'(1));
            w_eof  = (w_r == RW'(IMG_H - 2))
                  && (w_c == CW'(IMG_W - 2));
        end
        w_mt = PAD && (w_r == '0);
        w_mb = PAD && (w_r == RW'(IMG_H - 1));
        w_ml = PAD && (w_c == '0);
        w_mr = PAD && (w_c == CW'(IMG_W - 1));
        w_win[0] = (w_mt || w_ml) ? '0 : r_t1;
        w_win[1] = w_mt ? '0 : r_t2;
        w_win[2] = (w_mt || w_mr) ? '0 : w_lb1o;
        w_win[3] = w_ml ? '0 : r_m1;
        w_win[4] = r_m2;
        w_win[5] = w_mr ? '0 : w_lb0o;
        w_win[6] = (w_mb || w_ml) ? '0 : r_b1;
        w_win[7] = w_mb ? '0 : r_b2;
        w_win[8] = (w_mb || w_mr) ? '0 : w_pix;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < IMG_W; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
            r_t1 <= '0;
            r_t2 <= '0;
            r_m1 <= '0;
            r_m2 <= '0;
            r_b1 <= '0;
            r_b2 <= '0;
        end else if (w_adv) begin
            for (int i = IMG_W - 1; i > 0; i--) begin
                r_lb0[i] <= r_lb0[i-1];
                r_lb1[i] <= r_lb1[i-1];
            end
            r_lb0[0] <= w_pix;
            r_lb1[0] <= w_lb0o;
            r_t1     <= r_t2;
            r_t2     <= w_lb1o;
            r_m1     <= r_m2;
            r_m2     <= w_lb0o;
            r_b1     <= r_b2;
            r_b2     <= w_pix;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_o <= 1'b0;
            sof_o  <= 1'b0;
            eof_o  <= 1'b0;
            d0_o   <= '0;
            d1_o   <= '0;
            d2_o   <= '0;
            d3_o   <= '0;
            d4_o   <= '0;
            d5_o   <= '0;
            d6_o   <= '0;
            d7_o   <= '0;
            d8_o   <= '0;
        end else begin
            done_o <= w_trig;
            sof_o  <= w_trig && w_sof;
            eof_o  <= w_trig && w_eof;
            if (w_trig) begin
                d0_o <= w_win[0];
                d1_o <= w_win[1];
                d2_o <= w_win[2];
                d3_o <= w_win[3];
                d4_o <= w_win[4];
                d5_o <= w_win[5];
                d6_o <= w_win[6];
                d7_o <= w_win[7];
                d8_o <= w_win[8];
            end
        end
    end

endmodule
